// File: rtl/sensor_frame_transmitter.sv
// Sensor frame transmitter.
// Latches a 102-bit sensor result on a data_avl strobe and sends it to the host as a
// 15-byte UART 8N1 frame: SYNC_BYTE, 13 payload bytes (LSB byte first), XOR checksum.
//
// Ports:
//   clk_72MHz         sole clock, rising edge
//   reset_n           asynchronous active-low reset
//   sensor_iterations sensor result word, valid while data_avl=1
//   data_avl          single-cycle strobe qualifying sensor_iterations
//   tx                UART serial output, idles high
//   busy              high while a frame is in flight
//   reset_parser      one-cycle pulse on the cycle a frame completes
//   overrun_count     saturating count of strobes dropped while busy
module sensor_frame_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 625,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic         clk_72MHz,
  input  logic         reset_n,
  input  logic [101:0] sensor_iterations,
  input  logic         data_avl,
  output logic         tx,
  output logic         busy,
  output logic         reset_parser,
  output logic [7:0]   overrun_count
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state_q, state_d;
  logic [3:0]         byte_idx_q, byte_idx_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [12:0][7:0]   payload_q, payload_d;
  logic [7:0]         csum_q, csum_d;
  logic               rp_q, rp_d;
  logic [7:0]         ovr_q, ovr_d;

  logic [12:0][7:0]   payload_in;
  logic [7:0]         csum_in;
  logic [7:0]         cur_byte;
  logic               cnt_last;

  assign payload_in = {2'b00, sensor_iterations};
  assign cnt_last   = (cnt_q == CntLast);

  // Checksum is formed once at latch time so it is stable for the whole frame.
  always_comb begin
    csum_in = '0;
    for (int k = 0; k < 13; k++) begin
      csum_in = csum_in ^ payload_in[k];
    end
  end

  // Byte index 0 is the sync marker, 1..13 the payload, 14 the checksum.
  always_comb begin
    cur_byte = SYNC_BYTE;
    if (byte_idx_q == 4'd14) begin
      cur_byte = csum_q;
    end else if (byte_idx_q != 4'd0) begin
      cur_byte = payload_q[byte_idx_q - 4'd1];
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    payload_d  = payload_q;
    csum_d     = csum_q;
    rp_d       = 1'b0;
    ovr_d      = ovr_q;

    if (data_avl && (state_q != StIdle) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (data_avl) begin
          payload_d  = payload_in;
          csum_d     = csum_in;
          state_d    = StStart;
          byte_idx_d = 4'd0;
          bit_idx_d  = 3'd0;
          cnt_d      = '0;
        end
      end
      StStart: begin
        if (cnt_last) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (byte_idx_q == 4'd14) begin
            state_d = StIdle;
            rp_d    = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = StStart;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_72MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      payload_q  <= '0;
      csum_q     <= '0;
      rp_q       <= 1'b0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      payload_q  <= payload_d;
      csum_q     <= csum_d;
      rp_q       <= rp_d;
      ovr_q      <= ovr_d;
    end
  end

  // Outputs decode straight from registered state, so reset forces them idle at once.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      StIdle:  tx = 1'b1;
      StStart: tx = 1'b0;
      StData:  tx = cur_byte[bit_idx_q];
      StStop:  tx = 1'b1;
      default: tx = 1'b1;
    endcase
  end

  assign busy          = (state_q != StIdle);
  assign reset_parser  = rp_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_sensor_frame_transmitter.sv
// Directed bench for sensor_frame_transmitter with CLKS_PER_BIT=4 (600-cycle frames).
module tb_sensor_frame_transmitter;

  logic         clk;
  logic         reset_n;
  logic [101:0] si;
  logic         data_avl;
  logic         tx;
  logic         busy;
  logic         reset_parser;
  logic [7:0]   overrun_count;

  int total = 0;
  int bad   = 0;
  int exp_ovr = 0;

  sensor_frame_transmitter #(
    .CLKS_PER_BIT(4),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk_72MHz        (clk),
    .reset_n          (reset_n),
    .sensor_iterations(si),
    .data_avl         (data_avl),
    .tx               (tx),
    .busy             (busy),
    .reset_parser     (reset_parser),
    .overrun_count    (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_frame(input logic [101:0] v);
    @(negedge clk);
    si       = v;
    data_avl = 1'b1;
  endtask

  // Entered with data_avl already asserted for value v at the current negedge.
  task automatic check_frame(input logic [101:0] v, input int pulses, input bit scramble,
                             input bit chain, input logic [101:0] next_v, input string name);
    logic [7:0]   exp_b [15];
    logic [103:0] p;
    logic [127:0] r;
    logic         exp_tx;
    int           bi;
    int           bp;
    p         = {2'b00, v};
    exp_b[0]  = 8'hA5;
    exp_b[14] = 8'h00;
    for (int k = 0; k < 13; k++) begin
      exp_b[k+1] = p[8*k +: 8];
      exp_b[14]  = exp_b[14] ^ p[8*k +: 8];
    end
    @(negedge clk);
    data_avl = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bi = c / 40;
      bp = (c % 40) / 4;
      if (bp == 0)      exp_tx = 1'b0;
      else if (bp == 9) exp_tx = 1'b1;
      else              exp_tx = exp_b[bi][bp-1];
      total++;
      if (tx !== exp_tx || busy !== 1'b1 || reset_parser !== 1'b0) begin
        bad++;
        $display("FAIL %s cycle %0d byte %0d bit %0d: tx=%b busy=%b rp=%b, expected tx=%b busy=1 rp=0",
                 name, c, bi, bp, tx, busy, reset_parser, exp_tx);
      end
      data_avl = 1'b0;
      if ((c % 2 == 1) && (c / 2 < pulses)) begin
        data_avl = 1'b1;
        if (exp_ovr < 255) exp_ovr++;
      end
      if (scramble) begin
        r  = {$urandom(), $urandom(), $urandom(), $urandom()};
        si = r[101:0];
      end
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0 || reset_parser !== 1'b1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL %s end: busy=%b rp=%b tx=%b, expected busy=0 rp=1 tx=1",
               name, busy, reset_parser, tx);
    end
    total++;
    if (overrun_count !== 8'(exp_ovr)) begin
      bad++;
      $display("FAIL %s overrun: got %0d expected %0d", name, overrun_count, exp_ovr);
    end
    if (chain) begin
      si       = next_v;
      data_avl = 1'b1;
    end else begin
      data_avl = 1'b0;
      @(negedge clk);
      total++;
      if (reset_parser !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
        bad++;
        $display("FAIL %s after: rp=%b busy=%b tx=%b, expected rp=0 busy=0 tx=1",
                 name, reset_parser, busy, tx);
      end
    end
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    data_avl = 1'b0;
    si       = '0;
    repeat (3) @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || reset_parser !== 1'b0 || overrun_count !== 8'd0) begin
      bad++;
      $display("FAIL reset: tx=%b busy=%b rp=%b ovr=%0d, expected 1 0 0 0",
               tx, busy, reset_parser, overrun_count);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || reset_parser !== 1'b0) begin
      bad++;
      $display("FAIL idle: tx=%b busy=%b rp=%b, expected 1 0 0", tx, busy, reset_parser);
    end
  endtask

  task automatic test_single;
    start_frame(102'h1);
    check_frame(102'h1, 0, 1'b0, 1'b0, '0, "single");
  endtask

  task automatic test_all_ones;
    start_frame({102{1'b1}});
    check_frame({102{1'b1}}, 0, 1'b0, 1'b0, '0, "all_ones");
  endtask

  task automatic test_back_to_back;
    logic [101:0] a;
    logic [101:0] b;
    a = 102'h2_3456_789A_BCDE_F012_3456_789A;
    b = 102'h3_0F0F_00FF_8001_7E7E_C3C3_5A5A;
    start_frame(a);
    check_frame(a, 0, 1'b0, 1'b1, b, "b2b_first");
    check_frame(b, 0, 1'b0, 1'b0, '0, "b2b_second");
  endtask

  task automatic test_overrun;
    logic [101:0] v;
    v = 102'h1_DEAD_BEEF_CAFE_F00D_1234_5678;
    start_frame(v);
    check_frame(v, 3, 1'b0, 1'b0, '0, "overrun3");
    start_frame(102'h55);
    check_frame(102'h55, 300, 1'b0, 1'b0, '0, "overrun_sat");
  endtask

  task automatic test_scramble;
    logic [101:0] v;
    v = 102'h2_AAAA_5555_0123_4567_89AB_CDEF;
    start_frame(v);
    check_frame(v, 0, 1'b1, 1'b0, '0, "scramble");
  endtask

  task automatic test_abort;
    logic [101:0] v;
    start_frame(102'h3_FFFF_0000_FFFF_0000_FFFF_0000);
    @(negedge clk);
    data_avl = 1'b0;
    repeat (249) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || overrun_count !== 8'd0) begin
      bad++;
      $display("FAIL abort: tx=%b busy=%b ovr=%0d, expected tx=1 busy=0 ovr=0",
               tx, busy, overrun_count);
    end
    exp_ovr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (reset_parser !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort_hold %0d: rp=%b busy=%b, expected 0 0", i, reset_parser, busy);
      end
    end
    reset_n = 1'b1;
    v = 102'h0_1357_9BDF_2468_ACE0_1122_3344;
    start_frame(v);
    check_frame(v, 0, 1'b0, 1'b0, '0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ones();
    test_back_to_back();
    test_overrun();
    test_scramble();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
